// File: rtl/mem_stage_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory access unit.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] ones;
        case (size)
            SZ_B:    ones = 8'h01;
            SZ_H:    ones = 8'h03;
            SZ_W:    ones = 8'h0F;
            SZ_D:    ones = 8'hFF;
            default: ones = 8'h00;
        endcase
        return ones << lane;
    endfunction

    // An access is aligned when the low log2(bytes) address bits are zero.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = lane[0];
            SZ_W:    r = |lane[1:0];
            SZ_D:    r = |lane;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and the data memory.
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Extracts the addressed byte/half/word/double from a 64-bit read beat, zero-extended.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  lane,
    input  logic [1:0]  size,
    output logic [63:0] result
);

    logic [63:0] shifted_s;

    // Shift the addressed lane down to bit 0, then keep only the access width.
    always_comb begin
        shifted_s = rdata >> {lane, 3'b000};
        case (size)
            SZ_B:    result = {56'd0, shifted_s[7:0]};
            SZ_H:    result = {48'd0, shifted_s[15:0]};
            SZ_W:    result = {32'd0, shifted_s[31:0]};
            SZ_D:    result = shifted_s;
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: ALU results pass straight through, loads/stores run a
// req/ack transaction on the data-memory port while the pipeline is stalled.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_EXMEM,
    input  logic                RegWrite_EXMEM,
    input  logic                MemRead_EXMEM,
    input  logic                MemWrite_EXMEM,
    input  logic [1:0]          size_EXMEM,
    input  logic [4:0]          Rd_EXMEM,
    input  logic [63:0]         aluResult,
    input  logic [63:0]         storeData,
    mem_access_stage_if.master  mem,
    output logic                RegWrite_MEM,
    output logic [4:0]          Rd_MEM,
    output logic [63:0]         writeData,
    output logic                stall,
    output logic                mem_err
);

    localparam logic [7:0] MAX_CNT = MAX_WAIT[7:0];

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        err_r;
    logic        req_r;
    logic [63:0] addr_r;
    logic [63:0] wdata_r;
    logic [7:0]  be_r;
    logic        we_r;
    logic [1:0]  size_r;
    logic [2:0]  lane_r;
    logic [4:0]  rd_r;
    logic        load_r;
    logic        regw_r;
    logic [63:0] ldata_r;

    logic        mem_op_s;
    logic [7:0]  cnt_next_s;
    logic [63:0] align_s;
    logic        regw_mem_s;
    logic [4:0]  rd_mem_s;
    logic [63:0] wd_mem_s;
    logic        stall_s;

    assign mem_op_s   = valid_EXMEM & (MemRead_EXMEM | MemWrite_EXMEM);
    assign cnt_next_s = cnt_r + 8'd1;

    mem_lane_align u_align (
        .rdata  (mem.mem_rdata),
        .lane   (lane_r),
        .size   (size_r),
        .result (align_s)
    );

    // Transaction FSM with request latches, wait counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            err_r   <= 1'b0;
            req_r   <= 1'b0;
            addr_r  <= 64'd0;
            wdata_r <= 64'd0;
            be_r    <= 8'd0;
            we_r    <= 1'b0;
            size_r  <= 2'd0;
            lane_r  <= 3'd0;
            rd_r    <= 5'd0;
            load_r  <= 1'b0;
            regw_r  <= 1'b0;
            ldata_r <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        if (is_misaligned(size_EXMEM, aluResult[2:0])) begin
                            err_r   <= 1'b1;
                            state_r <= ERR;
                        end else begin
                            addr_r  <= {aluResult[63:3], 3'b000};
                            wdata_r <= storeData << {aluResult[2:0], 3'b000};
                            be_r    <= be_mask(size_EXMEM, aluResult[2:0]);
                            we_r    <= MemWrite_EXMEM;
                            size_r  <= size_EXMEM;
                            lane_r  <= aluResult[2:0];
                            rd_r    <= Rd_EXMEM;
                            load_r  <= MemRead_EXMEM;
                            regw_r  <= RegWrite_EXMEM;
                            cnt_r   <= 8'd0;
                            req_r   <= 1'b1;
                            state_r <= REQ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        ldata_r <= align_s;
                        req_r   <= 1'b0;
                        state_r <= DONE;
                    end else if (cnt_next_s == MAX_CNT) begin
                        err_r   <= 1'b1;
                        req_r   <= 1'b0;
                        state_r <= ERR;
                    end else begin
                        cnt_r   <= cnt_next_s;
                    end
                end
                DONE:    state_r <= IDLE;
                ERR:     state_r <= ERR;
                default: state_r <= ERR;
            endcase
        end
    end

    // Pipeline-side outputs: pass-through in IDLE, bubble while busy, result in DONE.
    always_comb begin
        regw_mem_s = 1'b0;
        rd_mem_s   = rd_r;
        wd_mem_s   = 64'd0;
        stall_s    = 1'b0;
        if (!reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_op_s) begin
                        stall_s = 1'b1;
                    end else begin
                        regw_mem_s = valid_EXMEM & RegWrite_EXMEM;
                        rd_mem_s   = Rd_EXMEM;
                        wd_mem_s   = aluResult;
                    end
                end
                REQ:  stall_s = 1'b1;
                DONE: begin
                    regw_mem_s = load_r & regw_r;
                    wd_mem_s   = load_r ? ldata_r : 64'd0;
                end
                ERR:     stall_s = 1'b1;
                default: stall_s = 1'b1;
            endcase
        end
    end

    assign mem.mem_req   = req_r;
    assign mem.mem_we    = we_r;
    assign mem.mem_addr  = addr_r;
    assign mem.mem_be    = be_r;
    assign mem.mem_wdata = wdata_r;
    assign RegWrite_MEM  = regw_mem_s;
    assign Rd_MEM        = rd_mem_s;
    assign writeData     = wd_mem_s;
    assign stall         = stall_s;
    assign mem_err       = err_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-lane memory model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_EXMEM, RegWrite_EXMEM, MemRead_EXMEM, MemWrite_EXMEM;
    logic [1:0]  size_EXMEM;
    logic [4:0]  Rd_EXMEM;
    logic [63:0] aluResult, storeData;
    logic        RegWrite_MEM, stall, mem_err;
    logic [4:0]  Rd_MEM;
    logic [63:0] writeData;
    int          tests = 0;
    int          fails = 0;

    mem_access_stage_if mif ();

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .valid_EXMEM(valid_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
        .MemRead_EXMEM(MemRead_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM), .size_EXMEM(size_EXMEM),
        .Rd_EXMEM(Rd_EXMEM), .aluResult(aluResult), .storeData(storeData), .mem(mif),
        .RegWrite_MEM(RegWrite_MEM), .Rd_MEM(Rd_MEM), .writeData(writeData),
        .stall(stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: bytes touched, enables, and zero-extended load value.
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [7:0] model_be(input logic [1:0] sz, input logic [63:0] addr);
        logic [7:0] be = 8'd0;
        for (int i = 0; i < nbytes(sz); i++) be[int'(addr[2:0]) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] model_load(input logic [1:0] sz, input logic [63:0] addr,
                                               input logic [63:0] rdata);
        logic [63:0] v = rdata >> (8 * int'(addr[2:0]));
        if (nbytes(sz) == 8) return v;
        return v & ((64'd1 << (8 * nbytes(sz))) - 64'd1);
    endfunction

    task automatic clear_inputs();
        valid_EXMEM = 1'b0; RegWrite_EXMEM = 1'b0; MemRead_EXMEM = 1'b0; MemWrite_EXMEM = 1'b0;
        size_EXMEM = 2'd0; Rd_EXMEM = 5'd0; aluResult = 64'd0; storeData = 64'd0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 64'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic alu_op(input logic v, input logic rw, input logic [4:0] rd,
                          input logic [63:0] alu, input logic mr, input string name);
        logic [71:0] got, exp;
        @(negedge clk);
        valid_EXMEM = v; RegWrite_EXMEM = rw; MemRead_EXMEM = mr; MemWrite_EXMEM = 1'b0;
        Rd_EXMEM = rd; aluResult = alu;
        #1;
        got = {stall, RegWrite_MEM, Rd_MEM, writeData, mif.mem_req};
        exp = {1'b0, v & rw, rd, alu, 1'b0};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s passthru: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_mem(input logic rd_op, input logic [1:0] sz, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic [63:0] rdata,
                           input logic [4:0] rd, input logic rw, input int waitc,
                           input string name);
        logic [75:0] got, exp;
        logic [70:0] dgot, dexp;
        logic [63:0] exp_wd;
        exp_wd = sdata << (8 * int'(addr[2:0]));
        @(negedge clk);
        valid_EXMEM = 1'b1; RegWrite_EXMEM = rw; MemRead_EXMEM = rd_op; MemWrite_EXMEM = ~rd_op;
        size_EXMEM = sz; Rd_EXMEM = rd; aluResult = addr; storeData = sdata; mif.mem_ack = 1'b0;
        #1;
        tests++;
        if ({stall, RegWrite_MEM, mif.mem_req} !== 3'b100) begin
            fails++;
            $display("FAIL %s issue: got %b expected 100", name, {stall, RegWrite_MEM, mif.mem_req});
        end
        for (int c = 0; c <= waitc; c++) begin
            @(negedge clk);
            mif.mem_ack   = (c == waitc);
            mif.mem_rdata = (c == waitc) ? rdata : {$urandom, $urandom};
            #1;
            got = {mif.mem_req, stall, RegWrite_MEM, mif.mem_we, mif.mem_addr, mif.mem_be};
            exp = {1'b1, 1'b1, 1'b0, ~rd_op, addr[63:3], 3'b000, model_be(sz, addr)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s req c=%0d: got %h expected %h", name, c, got, exp);
            end
            if (!rd_op) begin
                tests++;
                if (mif.mem_wdata !== exp_wd) begin
                    fails++;
                    $display("FAIL %s wdata: got %h expected %h", name, mif.mem_wdata, exp_wd);
                end
            end
        end
        @(negedge clk);
        mif.mem_ack = 1'b0;
        mif.mem_rdata = {$urandom, $urandom};
        #1;
        dgot = {stall, mif.mem_req, RegWrite_MEM, Rd_MEM, writeData};
        dexp = {1'b0, 1'b0, rd_op & rw, rd, rd_op ? model_load(sz, addr, rdata) : 64'd0};
        tests++;
        if (dgot !== dexp) begin
            fails++;
            $display("FAIL %s done: got %h expected %h", name, dgot, dexp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        valid_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1; Rd_EXMEM = 5'd5; aluResult = 64'd123;
        #1;
        tests++;
        if ({stall, RegWrite_MEM, writeData, mif.mem_req, mem_err} !== 68'd0) begin
            fails++;
            $display("FAIL reset: got %h expected 0",
                     {stall, RegWrite_MEM, writeData, mif.mem_req, mem_err});
        end
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
    endtask

    task automatic test_alu();
        alu_op(1'b1, 1'b1, 5'd7, 64'd538, 1'b0, "alu_538");
        alu_op(1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "alu_xzr");
        alu_op(1'b0, 1'b1, 5'd3, 64'd99, 1'b1, "alu_invalid_load");
        for (int i = 0; i < 8; i++)
            alu_op(1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom}, 1'b0, "alu_rand");
        clear_inputs();
    endtask

    task automatic test_directed_mem();
        run_mem(1'b1, 2'd3, 64'h100, 64'd0, 64'hDEADBEEF_CAFEF00D, 5'd9, 1'b1, 0, "ld_double");
        run_mem(1'b1, 2'd0, 64'h103, 64'd0, 64'h1122334455667788, 5'd4, 1'b1, 1, "ld_byte");
        run_mem(1'b0, 2'd2, 64'h104, 64'hAABBCCDD, 64'd0, 5'd2, 1'b1, 3, "st_word");
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [63:0] addr;
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                alu_op(1'b1, 1'($urandom), 5'($urandom), {$urandom, $urandom}, 1'b0, "b2b_alu");
            end else begin
                sz   = 2'($urandom);
                addr = {$urandom, $urandom} & ~(64'(nbytes(sz)) - 64'd1);
                run_mem(1'($urandom), sz, addr, {$urandom, $urandom}, {$urandom, $urandom},
                        5'($urandom), 1'($urandom), $urandom_range(0, 3), "b2b_mem");
            end
        end
        clear_inputs();
    endtask

    task automatic check_err_hold(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            mif.mem_ack = 1'($urandom);
            #1;
            tests++;
            if ({mem_err, mif.mem_req, stall, RegWrite_MEM} !== 4'b1010) begin
                fails++;
                $display("FAIL %s err_hold: got %b expected 1010", name,
                         {mem_err, mif.mem_req, stall, RegWrite_MEM});
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0] sz;
        for (int i = 0; i < 4; i++) begin
            sz = (i == 0) ? 2'd1 : 2'($urandom_range(1, 3));
            @(negedge clk);
            valid_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1; MemRead_EXMEM = 1'($urandom);
            MemWrite_EXMEM = ~MemRead_EXMEM; size_EXMEM = sz;
            aluResult = (i == 0) ? 64'h101 : ({$urandom, $urandom} | 64'd1);
            #1;
            tests++;
            if ({mem_err, mif.mem_req, stall} !== 3'b001) begin
                fails++;
                $display("FAIL misalign issue: got %b expected 001", {mem_err, mif.mem_req, stall});
            end
            check_err_hold("misalign", 3);
            do_reset();
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        valid_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1; MemRead_EXMEM = 1'b1; MemWrite_EXMEM = 1'b0;
        size_EXMEM = 2'd3; aluResult = 64'h200; mif.mem_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            tests++;
            if ({mif.mem_req, mem_err, stall} !== 3'b101) begin
                fails++;
                $display("FAIL timeout wait c=%0d: got %b expected 101", c,
                         {mif.mem_req, mem_err, stall});
            end
        end
        check_err_hold("timeout", 2);
        do_reset();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid_EXMEM = 1'b1; RegWrite_EXMEM = 1'b1; MemRead_EXMEM = 1'b1; MemWrite_EXMEM = 1'b0;
        size_EXMEM = 2'd2; aluResult = 64'h308; mif.mem_ack = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (mif.mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid req: got %b expected 1", mif.mem_req);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({mif.mem_req, mem_err, stall, RegWrite_MEM} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid drop: got %b expected 0000",
                     {mif.mem_req, mem_err, stall, RegWrite_MEM});
        end
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        mif.mem_ack = 1'b1;
        mif.mem_rdata = {$urandom, $urandom};
        for (int i = 0; i < 3; i++)
            alu_op(1'b1, 1'b1, 5'($urandom), {$urandom, $urandom}, 1'b0, "stray_ack");
        mif.mem_ack = 1'b0;
        run_mem(1'b1, 2'd1, 64'h40A, 64'd0, 64'h0123_4567_89AB_CDEF, 5'd12, 1'b1, 2, "post_rst_ld");
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_alu();
        test_directed_mem();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
